// File: rtl/axi_stream_pkg.sv
// Shared AXI Stream definitions: header-strip FSM states, the strip-count encoding and
// keep/byte-count helpers for MSB-aligned keep vectors.
package axi_stream_pkg;

    localparam int MAX_BYTES = 64;

    typedef enum logic [1:0] {
        IDLE,
        FIRST,
        STREAM,
        FLUSH
    } state_t;

    // byte_strip_cnt encodes S-1, so a zero on the wire strips one byte
    function automatic int strip_bytes(input int byte_strip_cnt);
        return byte_strip_cnt + 1;
    endfunction

    function automatic int keep_to_cnt(input logic [MAX_BYTES-1:0] keep);
        int n;
        n = 0;
        for (int i = 0; i < MAX_BYTES; i++) begin
            if (keep[i]) n = n + 1;
        end
        return n;
    endfunction

    function automatic logic [MAX_BYTES-1:0] cnt_to_keep(input int cnt, input int width);
        logic [MAX_BYTES-1:0] k;
        k = '0;
        for (int i = 0; i < MAX_BYTES; i++) begin
            if ((i < width) && (i >= width - cnt)) k[i] = 1'b1;
        end
        return k;
    endfunction

endpackage

// File: rtl/axi_stream_byte_realign.sv
// Combinational byte shifter: splits a beat at the strip point and merges the carried
// residue with the head of the next beat, all MSB-aligned.
module axi_stream_byte_realign #(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
    input  logic [DATA_WD-1:0]      data,
    input  logic [DATA_BYTE_WD-1:0] keep,
    input  logic [DATA_WD-1:0]      residue,
    input  logic [BYTE_CNT_WD:0]    strip,
    output logic [DATA_WD-1:0]      tail_data,
    output logic [DATA_BYTE_WD-1:0] tail_keep,
    output logic [DATA_WD-1:0]      merge_data,
    output logic [DATA_BYTE_WD-1:0] merge_keep,
    output logic                    beyond_strip
);
    import axi_stream_pkg::*;

    logic [DATA_WD-1:0] masked;
    int                 s;

    // Tail = bytes S.. of the beat; merge = residue followed by the first S bytes
    always_comb begin
        s = int'(strip);
        masked = '0;
        for (int i = 0; i < DATA_BYTE_WD; i++) begin
            masked[8*i +: 8] = data[8*i +: 8] & {8{keep[i]}};
        end
        tail_data    = masked << (8 * s);
        tail_keep    = keep << s;
        merge_data   = residue | (masked >> (8 * (DATA_BYTE_WD - s)));
        merge_keep   = DATA_BYTE_WD'(cnt_to_keep(DATA_BYTE_WD - s, DATA_BYTE_WD))
                     | (keep >> (DATA_BYTE_WD - s));
        beyond_strip = keep_to_cnt(MAX_BYTES'(keep)) > s;
    end

endmodule

// File: rtl/axi_stream_remove_header.sv
// Strips a per-packet count of leading bytes from an AXI Stream and repacks the
// remainder MSB-aligned, with a single registered output stage.
module axi_stream_remove_header #(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    valid_in,
    input  logic [DATA_WD-1:0]      data_in,
    input  logic [DATA_BYTE_WD-1:0] keep_in,
    input  logic                    last_in,
    output logic                    ready_in,
    output logic                    valid_out,
    output logic [DATA_WD-1:0]      data_out,
    output logic [DATA_BYTE_WD-1:0] keep_out,
    output logic                    last_out,
    input  logic                    ready_out,
    input  logic                    valid_strip,
    input  logic [BYTE_CNT_WD-1:0]  byte_strip_cnt,
    output logic                    ready_strip
);
    import axi_stream_pkg::*;

    state_t                  state;
    logic [BYTE_CNT_WD:0]    strip;
    logic [DATA_WD-1:0]      residue;
    logic [DATA_BYTE_WD-1:0] residue_keep;
    logic [DATA_WD-1:0]      tail_data;
    logic [DATA_BYTE_WD-1:0] tail_keep;
    logic [DATA_WD-1:0]      merge_data;
    logic [DATA_BYTE_WD-1:0] merge_keep;
    logic                    beyond_strip;
    logic                    load_ok;
    logic                    accept;

    axi_stream_byte_realign #(
        .DATA_WD      (DATA_WD),
        .DATA_BYTE_WD (DATA_BYTE_WD),
        .BYTE_CNT_WD  (BYTE_CNT_WD)
    ) u_realign (
        .data         (data_in),
        .keep         (keep_in),
        .residue      (residue),
        .strip        (strip),
        .tail_data    (tail_data),
        .tail_keep    (tail_keep),
        .merge_data   (merge_data),
        .merge_keep   (merge_keep),
        .beyond_strip (beyond_strip)
    );

    assign load_ok     = !valid_out || ready_out;
    assign ready_strip = (state == IDLE);
    assign ready_in    = ((state == FIRST) || (state == STREAM)) && load_ok;
    assign accept      = valid_in && ready_in;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            strip        <= '0;
            residue      <= '0;
            residue_keep <= '0;
            valid_out    <= 1'b0;
            data_out     <= '0;
            keep_out     <= '0;
            last_out     <= 1'b0;
        end else begin
            if (valid_out && ready_out) valid_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (valid_strip) begin
                        strip <= (BYTE_CNT_WD+1)'(strip_bytes(int'(byte_strip_cnt)));
                        state <= FIRST;
                    end
                end
                FIRST: begin
                    if (accept) begin
                        residue      <= tail_data;
                        residue_keep <= tail_keep;
                        if (last_in) begin
                            state <= IDLE;
                            if (beyond_strip) begin
                                valid_out <= 1'b1;
                                data_out  <= tail_data;
                                keep_out  <= tail_keep;
                                last_out  <= 1'b1;
                            end
                        end else begin
                            state <= STREAM;
                        end
                    end
                end
                STREAM: begin
                    // A last beat longer than S leaves residue that needs its own beat
                    if (accept) begin
                        valid_out    <= 1'b1;
                        data_out     <= merge_data;
                        keep_out     <= merge_keep;
                        last_out     <= last_in && !beyond_strip;
                        residue      <= tail_data;
                        residue_keep <= tail_keep;
                        if (last_in) state <= beyond_strip ? FLUSH : IDLE;
                    end
                end
                FLUSH: begin
                    if (load_ok) begin
                        valid_out <= 1'b1;
                        data_out  <= residue;
                        keep_out  <= residue_keep;
                        last_out  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/axi_stream_remove_header.md
AXI_STREAM_REMOVE_HEADER -- requirements
Module: axi_stream_remove_header

Interface
REQ-001 SHALL have parameter DATA_WD, default 32, meaning stream data width in bits.
REQ-002 SHALL have parameter DATA_BYTE_WD, default DATA_WD/8, meaning bytes per beat.
REQ-003 SHALL have parameter BYTE_CNT_WD, default $clog2(DATA_BYTE_WD), meaning width of the strip-count field.
REQ-004 SHALL have one clock and an asynchronous, active-high reset, listed first: clk  input  1  clock, all logic on the rising edge; rst  input  1  asynchronous active-high reset.
REQ-005 SHALL have the AXI Stream input ports: valid_in  input  1; data_in  input  DATA_WD; keep_in  input  DATA_BYTE_WD; last_in  input  1; ready_in  output  1.
REQ-006 SHALL have the AXI Stream output ports: valid_out  output  1; data_out  output  DATA_WD; keep_out  output  DATA_BYTE_WD; last_out  output  1; ready_out  input  1.
REQ-007 SHALL have the strip-command ports: valid_strip  input  1; byte_strip_cnt  input  BYTE_CNT_WD, where the strip count S = byte_strip_cnt+1 bytes (1..DATA_BYTE_WD); ready_strip  output  1.

Function
REQ-008 SHALL use MSB-first byte order: byte 0 = data[DATA_WD-1 -: 8], and keep bit DATA_BYTE_WD-1 qualifies byte 0.
REQ-009 SHALL require input non-last beats to carry all-ones keep, and last beats to carry a nonzero, MSB-contiguous keep; any other input is undefined behaviour.
REQ-010 SHALL remove exactly S leading bytes from each packet and output the remaining bytes repacked MSB-aligned, in the same format as REQ-009, with unused output bytes driven to zero.
REQ-011 SHALL implement the states IDLE, FIRST, STREAM and FLUSH.
REQ-012 In IDLE, SHALL drive ready_strip=1 and ready_in=0; a strip handshake SHALL latch S and move to FIRST; valid_strip SHALL be ignored in every other state.
REQ-013 In FIRST and STREAM, SHALL drive ready_in = !valid_out || ready_out, combinational on ready_out; in FLUSH, ready_in SHALL be 0.
REQ-014 On a FIRST beat, SHALL store bytes S..DATA_BYTE_WD-1 as a residue and output nothing.
REQ-015 In FIRST, if last_in is set with n valid bytes, SHALL output a single last beat of n-S bytes when n>S, output no beat when n<=S, and return to IDLE in both cases; otherwise SHALL go to STREAM.
REQ-016 On a STREAM beat, SHALL output residue(DATA_BYTE_WD-S bytes) followed by the first S bytes of the beat, and SHALL store bytes S.. of the beat as the new residue; when S=DATA_BYTE_WD, the beat SHALL pass through unchanged.
REQ-017 On a STREAM last beat with n valid bytes: when n<=S, SHALL output a last beat with keep of (DATA_BYTE_WD-S)+n ones and go to IDLE; when n>S, SHALL output a full beat and go to FLUSH.
REQ-018 In FLUSH, SHALL load a last beat holding the n-S residue bytes into the output register when it is free, then go to IDLE.
REQ-019 SHALL register all outputs, with a latency of one cycle from input accept to valid_out, and SHALL load the output register only when !valid_out || ready_out.
REQ-020 SHALL hold data_out, keep_out and last_out stable while valid_out && !ready_out, and SHALL neither drop nor duplicate beats.

Reset
REQ-021 While rst=1, SHALL hold state=IDLE, valid_out=0, data_out=0, keep_out=0, last_out=0, residue=0, ready_in=0 and ready_strip=1.
REQ-022 On reset assertion mid-packet, SHALL discard the partial packet and the latched S, and SHALL force valid_out to 0 immediately without waiting for a clock edge.

Structure
REQ-023 SHALL take the state enum, the strip-count encoding, and the functions keep_to_cnt (popcount of an MSB-aligned keep) and cnt_to_keep from the shared package axi_stream_pkg.
REQ-024 SHALL place the combinational byte-merge/shift datapath in one sub-module, axi_stream_byte_realign, with the FSM and output register in the top level.

Verification
REQ-025 SHALL cover: cnt=1, beats 0xAABBCCDD, 0x11223344, 0x55660000 (keep 1100, last) -> 0xCCDD1122 (keep 1111), then 0x33445566 (keep 1111, last).
REQ-026 SHALL cover: cnt=0, beats 0xAABBCCDD, 0x11223300 (keep 1110, last) -> 0xBBCCDD11 (1111), then 0x22330000 (keep 1100, last) via FLUSH, with ready_in=0 during FLUSH.
REQ-027 SHALL cover: cnt=3, beats 0xAABBCCDD, 0x11223344 (last) -> single beat 0x11223344 (keep 1111, last).
REQ-028 SHALL cover: cnt=2, single beat 0xAABBCCDD with keep 1100 (last) -> no output and ready_strip=1 next cycle; the same with keep 1111 -> 0xDD000000 (keep 1000, last).
REQ-029 SHALL cover: the REQ-025 stimulus with ready_out low for 5 cycles mid-packet -> outputs stable, ready_in=0, identical output sequence.
REQ-030 SHALL cover: rst pulsed after the first beat of REQ-025 -> valid_out=0 at once, ready_strip=1, and a following clean packet processed correctly.
